// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: substitutes LANES bytes of a 128-bit state per cycle
// through a shared bank of inverse S-box tables, with valid/ready on both sides.
module inv_sub_bytes_iter #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   localparam int C  = 16 / LANES;
   localparam int CW = (C > 1) ? $clog2(C) : 1;
   localparam int GW = LANES * 8;

   localparam logic [7:0] INV_SBOX [0:255] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_nxt;
   logic [127:0]    w, w_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [7:0]      base;
   logic [GW-1:0]   grp_in, grp_out;

   // The active byte group sits at bit offset cnt*GW; only LANES tables are built.
   assign base   = 8'(cnt) * 8'(GW);
   assign grp_in = w[base +: GW];

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign grp_out[l*8 +: 8] = INV_SBOX[grp_in[l*8 +: 8]];
   end

   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign out_data  = w;

   always_comb begin
      state_nxt = state;
      w_nxt     = w;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (in_valid && in_ready) begin
               w_nxt     = in_data;
               cnt_nxt   = '0;
               state_nxt = RUN;
            end
         end
         RUN: begin
            w_nxt[base +: GW] = grp_out;
            if (cnt == CW'(C - 1)) begin
               cnt_nxt   = '0;
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         w     <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         w     <= w_nxt;
         cnt   <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Directed and round-trip bench for inv_sub_bytes_iter: a LANES=4 instance for
// the main scenarios plus LANES=1/2/8/16 instances for the latency sweep.
module tb_inv_sub_bytes_iter;

   localparam logic [7:0] FWD_SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, out_valid, out_ready, busy;
   logic [127:0] in_data, out_data;

   logic         sw_in_valid, sw_out_ready;
   logic [127:0] sw_in_data;
   logic         sw_in_ready  [4];
   logic         sw_out_valid [4];
   logic         sw_busy      [4];
   logic [127:0] sw_out_data  [4];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   inv_sub_bytes_iter #(.LANES(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy));

   inv_sub_bytes_iter #(.LANES(1)) dut_l1 (
      .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(sw_in_ready[0]), .in_data(sw_in_data),
      .out_valid(sw_out_valid[0]), .out_ready(sw_out_ready), .out_data(sw_out_data[0]), .busy(sw_busy[0]));
   inv_sub_bytes_iter #(.LANES(2)) dut_l2 (
      .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(sw_in_ready[1]), .in_data(sw_in_data),
      .out_valid(sw_out_valid[1]), .out_ready(sw_out_ready), .out_data(sw_out_data[1]), .busy(sw_busy[1]));
   inv_sub_bytes_iter #(.LANES(8)) dut_l8 (
      .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(sw_in_ready[2]), .in_data(sw_in_data),
      .out_valid(sw_out_valid[2]), .out_ready(sw_out_ready), .out_data(sw_out_data[2]), .busy(sw_busy[2]));
   inv_sub_bytes_iter #(.LANES(16)) dut_l16 (
      .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(sw_in_ready[3]), .in_data(sw_in_data),
      .out_valid(sw_out_valid[3]), .out_ready(sw_out_ready), .out_data(sw_out_data[3]), .busy(sw_busy[3]));

   // Every task starts and ends just after a falling edge, so inputs settle well before the next rising edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [127:0] fwd_state(input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[i*8 +: 8] = FWD_SBOX[s[i*8 +: 8]];
      return r;
   endfunction

   task automatic send_block(input logic [127:0] d, output logic [127:0] r, output int lat);
      lat      = -1;
      r        = '0;
      in_data  = d;
      in_valid = 1'b1;
      for (int i = 0; i < 50 && !in_ready; i++) step();
      step();
      in_valid = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         step();
         if (out_valid) begin
            lat = n;
            r   = out_data;
            break;
         end
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b1;
      step();
      step();
      tests++;
      if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
      tests++;
      if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      tests++;
      if (out_data !== 128'h0) begin fails++; $display("[TB] FAIL reset_w: got %h expected 0", out_data); end
      rst = 1'b0;
      in_valid = 1'b0;
      step();
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL post_reset_in_ready: got %b expected 1", in_ready); end
      for (int k = 0; k < 4; k++) begin
         tests++;
         if (sw_in_ready[k] !== 1'b1 || sw_busy[k] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL sweep_reset[%0d]: got ready=%b busy=%b expected ready=1 busy=0", k, sw_in_ready[k], sw_busy[k]);
         end
      end
   endtask

   task automatic test_known();
      logic [127:0] vin [5];
      logic [127:0] vexp [5];
      logic [127:0] r;
      int lat;
      vin[0] = {16{8'h63}};  vexp[0] = 128'h0;
      vin[1] = 128'h0;       vexp[1] = {16{8'h52}};
      vin[2] = {16{8'h16}};  vexp[2] = {16{8'hff}};
      vin[3] = {{13{8'h00}}, 8'h7c, 8'hff, 8'h01};
      vexp[3] = {{13{8'h52}}, 8'h01, 8'h7d, 8'h09};
      vin[4] = 128'h0f0e0d0c0b0a09080706050403020100;
      vexp[4] = 128'hfbd7f3819ea340bf38a53630d56a0952;
      for (int i = 0; i < 5; i++) begin
         send_block(vin[i], r, lat);
         tests++;
         if (r !== vexp[i]) begin fails++; $display("[TB] FAIL known_data[%0d]: got %h expected %h", i, r, vexp[i]); end
         tests++;
         if (lat != 4) begin fails++; $display("[TB] FAIL known_latency[%0d]: got %0d expected 4", i, lat); end
      end
   endtask

   task automatic test_backpressure();
      int seen = 0;
      in_data  = {16{8'h16}};
      in_valid = 1'b1;
      step();
      in_data  = 128'h0;
      for (int n = 0; n < 20 && !out_valid; n++) step();
      for (int c = 0; c < 10; c++) begin
         tests++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== {16{8'hff}}) begin
            fails++;
            $display("[TB] FAIL backpressure[%0d]: got valid=%b ready=%b data=%h expected valid=1 ready=0 data=%h",
                     c, out_valid, in_ready, out_data, {16{8'hff}});
         end
         step();
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("[TB] FAIL backpressure_release: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
      end
      step();
      if (busy) seen = 1;
      tests++;
      if (seen != 0) begin fails++; $display("[TB] FAIL backpressure_no_capture: got busy=%0d expected 0", seen); end
   endtask

   task automatic test_reset_mid();
      logic [127:0] r;
      int lat;
      int spurious = 0;
      in_data  = {16{8'h63}};
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      tests++;
      if (busy !== 1'b1) begin fails++; $display("[TB] FAIL mid_busy_before: got %b expected 1", busy); end
      rst = 1'b1;
      step();
      tests++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 128'h0 || in_ready !== 1'b0) begin
         fails++;
         $display("[TB] FAIL mid_reset_state: got busy=%b valid=%b ready=%b w=%h expected 0 0 0 0",
                  busy, out_valid, in_ready, out_data);
      end
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         step();
         if (out_valid || busy) spurious++;
      end
      tests++;
      if (spurious != 0) begin fails++; $display("[TB] FAIL mid_dropped: got %0d active cycles expected 0", spurious); end
      send_block(128'h0, r, lat);
      tests++;
      if (r !== {16{8'h52}} || lat != 4) begin
         fails++;
         $display("[TB] FAIL mid_next_block: got %h lat %0d expected %h lat 4", r, lat, {16{8'h52}});
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] vin [4];
      logic [127:0] vexp [4];
      int pulse_t [4];
      int k_in = 0;
      int k_out = 0;
      int cyc = 0;
      vin[0] = 128'h0;                              vexp[0] = {16{8'h52}};
      vin[1] = {16{8'h63}};                         vexp[1] = 128'h0;
      vin[2] = {16{8'h16}};                         vexp[2] = {16{8'hff}};
      vin[3] = 128'h0f0e0d0c0b0a09080706050403020100; vexp[3] = 128'hfbd7f3819ea340bf38a53630d56a0952;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      while (k_out < 4 && cyc < 80) begin
         if (out_valid) begin
            tests++;
            if (out_data !== vexp[k_out]) begin
               fails++;
               $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", k_out, out_data, vexp[k_out]);
            end
            k_out++;
         end
         if (in_ready) begin
            if (k_in < 4) begin
               pulse_t[k_in] = cyc;
               in_data = vin[k_in];
               k_in++;
            end else begin
               in_valid = 1'b0;
            end
         end
         step();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tests++;
      if (k_out != 4 || k_in != 4) begin fails++; $display("[TB] FAIL b2b_count: got in=%0d out=%0d expected 4 4", k_in, k_out); end
      for (int i = 1; i < k_in; i++) begin
         tests++;
         if (pulse_t[i] - pulse_t[i-1] != 6) begin
            fails++;
            $display("[TB] FAIL b2b_gap[%0d]: got %0d expected 6", i, pulse_t[i] - pulse_t[i-1]);
         end
      end
   endtask

   task automatic test_sweep();
      int lat [4] = '{-1, -1, -1, -1};
      int exp_lat [4] = '{16, 8, 2, 1};
      logic [127:0] res [4];
      sw_out_ready = 1'b1;
      sw_in_data   = {16{8'h63}};
      sw_in_valid  = 1'b1;
      step();
      sw_in_valid  = 1'b0;
      for (int n = 1; n <= 24; n++) begin
         step();
         for (int k = 0; k < 4; k++) begin
            if (sw_out_valid[k] && lat[k] < 0) begin
               lat[k] = n;
               res[k] = sw_out_data[k];
            end
         end
      end
      for (int k = 0; k < 4; k++) begin
         tests++;
         if (lat[k] != exp_lat[k]) begin
            fails++;
            $display("[TB] FAIL sweep_latency[%0d]: got %0d expected %0d", k, lat[k], exp_lat[k]);
         end
         tests++;
         if (lat[k] < 0 || res[k] !== 128'h0) begin
            fails++;
            $display("[TB] FAIL sweep_data[%0d]: got %h expected 0", k, res[k]);
         end
      end
      sw_out_ready = 1'b0;
   endtask

   task automatic test_round_trip();
      localparam int N = 1000;
      logic [127:0] exp_q [$];
      logic [127:0] orig;
      int sent = 0;
      int rcv = 0;
      int cyc = 0;
      while (rcv < N && cyc < 40000) begin
         out_ready = ($urandom_range(0, 2) != 0);
         if (out_valid && out_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("[TB] FAIL roundtrip_extra[%0d]: got %h expected no output", rcv, out_data);
            end else begin
               orig = exp_q.pop_front();
               if (out_data !== orig) begin
                  fails++;
                  $display("[TB] FAIL roundtrip[%0d]: got %h expected %h", rcv, out_data, orig);
               end
            end
            rcv++;
         end
         if (sent < N && $urandom_range(0, 3) != 0) begin
            orig     = {$urandom, $urandom, $urandom, $urandom};
            in_valid = 1'b1;
            in_data  = fwd_state(orig);
            if (in_ready) begin
               exp_q.push_back(orig);
               sent++;
            end
         end else begin
            in_valid = 1'b0;
         end
         step();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tests++;
      if (rcv != N || exp_q.size() != 0) begin
         fails++;
         $display("[TB] FAIL roundtrip_count: got %0d received, %0d pending expected %0d received, 0 pending",
                  rcv, exp_q.size(), N);
      end
   endtask

   initial begin
      rst          = 1'b1;
      in_valid     = 1'b0;
      in_data      = '0;
      out_ready    = 1'b0;
      sw_in_valid  = 1'b0;
      sw_in_data   = '0;
      sw_out_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_known();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_sweep();
      test_round_trip();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
